// File: rtl/instr_encoder.sv
//============================================================================
// Module      : instr_encoder
// Description : Encodes a mnemonic select plus operand fields into a 32-bit
//               MIPS-style instruction word. The word is held in a single
//               output register with a valid/ready handshake. Each word that
//               drains produces a write strobe and a byte address that steps
//               through the instruction memory and wraps at DEPTH_WORDS.
//               Optional feature macro: ENC_ILLEGAL_CHECK_EN. When defined,
//               illegal selects are dropped and raise a sticky Error. When
//               undefined, illegal selects encode as a nop and Error is 0.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module instr_encoder #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [4:0]  OpSel,
    input  logic [4:0]  Rs,
    input  logic [4:0]  Rt,
    input  logic [4:0]  Rd,
    input  logic [4:0]  Shamt,
    input  logic [15:0] Imm,
    input  logic [25:0] Target,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] Instruction,
    output logic [31:0] InstrAddr,
    output logic        WrEn,
    output logic        Error
);

    // Word-index width; the byte address is this index shifted left by two.
    localparam int c_addr_w = $clog2(DEPTH_WORDS);

    // Mnemonic select codes
    localparam logic [4:0] c_sel_sll  = 5'd0;
    localparam logic [4:0] c_sel_srl  = 5'd1;
    localparam logic [4:0] c_sel_add  = 5'd2;
    localparam logic [4:0] c_sel_sub  = 5'd3;
    localparam logic [4:0] c_sel_and  = 5'd4;
    localparam logic [4:0] c_sel_or   = 5'd5;
    localparam logic [4:0] c_sel_xor  = 5'd6;
    localparam logic [4:0] c_sel_nor  = 5'd7;
    localparam logic [4:0] c_sel_slt  = 5'd8;
    localparam logic [4:0] c_sel_jr   = 5'd9;
    localparam logic [4:0] c_sel_mul  = 5'd10;
    localparam logic [4:0] c_sel_lw   = 5'd11;
    localparam logic [4:0] c_sel_lb   = 5'd12;
    localparam logic [4:0] c_sel_lh   = 5'd13;
    localparam logic [4:0] c_sel_sw   = 5'd14;
    localparam logic [4:0] c_sel_sb   = 5'd15;
    localparam logic [4:0] c_sel_sh   = 5'd16;
    localparam logic [4:0] c_sel_addi = 5'd17;
    localparam logic [4:0] c_sel_andi = 5'd18;
    localparam logic [4:0] c_sel_ori  = 5'd19;
    localparam logic [4:0] c_sel_xori = 5'd20;
    localparam logic [4:0] c_sel_slti = 5'd21;
    localparam logic [4:0] c_sel_beq  = 5'd22;
    localparam logic [4:0] c_sel_bne  = 5'd23;
    localparam logic [4:0] c_sel_bgez = 5'd24;
    localparam logic [4:0] c_sel_bltz = 5'd25;
    localparam logic [4:0] c_sel_bgtz = 5'd26;
    localparam logic [4:0] c_sel_blez = 5'd27;
    localparam logic [4:0] c_sel_j    = 5'd28;
    localparam logic [4:0] c_sel_jal  = 5'd29;

    // Primary opcodes
    localparam logic [5:0] c_op_special = 6'b000000;
    localparam logic [5:0] c_op_regimm  = 6'b000001;
    localparam logic [5:0] c_op_j       = 6'b000010;
    localparam logic [5:0] c_op_jal     = 6'b000011;
    localparam logic [5:0] c_op_beq     = 6'b000100;
    localparam logic [5:0] c_op_bne     = 6'b000101;
    localparam logic [5:0] c_op_blez    = 6'b000110;
    localparam logic [5:0] c_op_bgtz    = 6'b000111;
    localparam logic [5:0] c_op_addi    = 6'b001000;
    localparam logic [5:0] c_op_slti    = 6'b001010;
    localparam logic [5:0] c_op_andi    = 6'b001100;
    localparam logic [5:0] c_op_ori     = 6'b001101;
    localparam logic [5:0] c_op_xori    = 6'b001110;
    localparam logic [5:0] c_op_special2 = 6'b011100;
    localparam logic [5:0] c_op_lb      = 6'b100000;
    localparam logic [5:0] c_op_lh      = 6'b100001;
    localparam logic [5:0] c_op_lw      = 6'b100011;
    localparam logic [5:0] c_op_sb      = 6'b101000;
    localparam logic [5:0] c_op_sh      = 6'b101001;
    localparam logic [5:0] c_op_sw      = 6'b101011;

    // Function codes for the special opcodes
    localparam logic [5:0] c_fn_sll = 6'b000000;
    localparam logic [5:0] c_fn_srl = 6'b000010;
    localparam logic [5:0] c_fn_jr  = 6'b001000;
    localparam logic [5:0] c_fn_add = 6'b100000;
    localparam logic [5:0] c_fn_sub = 6'b100010;
    localparam logic [5:0] c_fn_and = 6'b100100;
    localparam logic [5:0] c_fn_or  = 6'b100101;
    localparam logic [5:0] c_fn_xor = 6'b100110;
    localparam logic [5:0] c_fn_nor = 6'b100111;
    localparam logic [5:0] c_fn_slt = 6'b101010;
    localparam logic [5:0] c_fn_mul = 6'b000010;

    localparam logic [4:0] c_zero5 = 5'd0;

    logic                out_valid_q;
    logic                out_valid_d;
    logic [31:0]         instruction_q;
    logic [31:0]         instruction_d;
    logic [c_addr_w-1:0] addr_q;
    logic [c_addr_w-1:0] addr_d;

    logic [31:0]         w_encoded;
    logic                w_accept;
    logic                w_wr_en;

    // Handshake: the single output register frees up when it is empty or draining.
    assign InReady  = !out_valid_q || OutReady;
    assign w_accept = InValid && InReady;
    assign w_wr_en  = out_valid_q && OutReady;

    assign OutValid    = out_valid_q;
    assign Instruction = instruction_q;
    assign InstrAddr   = {{(30 - c_addr_w){1'b0}}, addr_q, 2'b00};
    assign WrEn        = w_wr_en;

    // Field packing per mnemonic, with forced-zero / forced-constant fields.
    always_comb begin
        w_encoded = 32'h0000_0000;
        case (OpSel)
            c_sel_sll:  w_encoded = {c_op_special, c_zero5, Rt, Rd, Shamt, c_fn_sll};
            c_sel_srl:  w_encoded = {c_op_special, c_zero5, Rt, Rd, Shamt, c_fn_srl};
            c_sel_add:  w_encoded = {c_op_special, Rs, Rt, Rd, c_zero5, c_fn_add};
            c_sel_sub:  w_encoded = {c_op_special, Rs, Rt, Rd, c_zero5, c_fn_sub};
            c_sel_and:  w_encoded = {c_op_special, Rs, Rt, Rd, c_zero5, c_fn_and};
            c_sel_or:   w_encoded = {c_op_special, Rs, Rt, Rd, c_zero5, c_fn_or};
            c_sel_xor:  w_encoded = {c_op_special, Rs, Rt, Rd, c_zero5, c_fn_xor};
            c_sel_nor:  w_encoded = {c_op_special, Rs, Rt, Rd, c_zero5, c_fn_nor};
            c_sel_slt:  w_encoded = {c_op_special, Rs, Rt, Rd, c_zero5, c_fn_slt};
            c_sel_jr:   w_encoded = {c_op_special, Rs, c_zero5, c_zero5, c_zero5, c_fn_jr};
            c_sel_mul:  w_encoded = {c_op_special2, Rs, Rt, Rd, c_zero5, c_fn_mul};
            c_sel_lw:   w_encoded = {c_op_lw, Rs, Rt, Imm};
            c_sel_lb:   w_encoded = {c_op_lb, Rs, Rt, Imm};
            c_sel_lh:   w_encoded = {c_op_lh, Rs, Rt, Imm};
            c_sel_sw:   w_encoded = {c_op_sw, Rs, Rt, Imm};
            c_sel_sb:   w_encoded = {c_op_sb, Rs, Rt, Imm};
            c_sel_sh:   w_encoded = {c_op_sh, Rs, Rt, Imm};
            c_sel_addi: w_encoded = {c_op_addi, Rs, Rt, Imm};
            c_sel_andi: w_encoded = {c_op_andi, Rs, Rt, Imm};
            c_sel_ori:  w_encoded = {c_op_ori, Rs, Rt, Imm};
            c_sel_xori: w_encoded = {c_op_xori, Rs, Rt, Imm};
            c_sel_slti: w_encoded = {c_op_slti, Rs, Rt, Imm};
            c_sel_beq:  w_encoded = {c_op_beq, Rs, Rt, Imm};
            c_sel_bne:  w_encoded = {c_op_bne, Rs, Rt, Imm};
            c_sel_bgez: w_encoded = {c_op_regimm, Rs, 5'b00001, Imm};
            c_sel_bltz: w_encoded = {c_op_regimm, Rs, 5'b00000, Imm};
            c_sel_bgtz: w_encoded = {c_op_bgtz, Rs, c_zero5, Imm};
            c_sel_blez: w_encoded = {c_op_blez, Rs, c_zero5, Imm};
            c_sel_j:    w_encoded = {c_op_j, Target};
            c_sel_jal:  w_encoded = {c_op_jal, Target};
            default:    w_encoded = 32'h0000_0000;
        endcase
    end

`ifdef ENC_ILLEGAL_CHECK_EN
    logic w_illegal;
    logic error_q;
    logic error_d;

    assign w_illegal = (OpSel >= 5'd30);
    assign Error     = error_q;

    // Sticky illegal-select flag, cleared only by reset.
    always_comb begin
        error_d = error_q | (w_accept & w_illegal);
    end

    // Error flag register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end
`else
    assign Error = 1'b0;
`endif

    // Output register / address counter next state; drain and load may coincide.
    always_comb begin
        out_valid_d   = out_valid_q;
        instruction_d = instruction_q;
        addr_d        = addr_q;
        if (w_wr_en) begin
            out_valid_d = 1'b0;
            addr_d      = addr_q + c_addr_w'(1);
        end
        if (w_accept) begin
`ifdef ENC_ILLEGAL_CHECK_EN
            if (!w_illegal) begin
                out_valid_d   = 1'b1;
                instruction_d = w_encoded;
            end
`else
            out_valid_d   = 1'b1;
            instruction_d = w_encoded;
`endif
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid_q   <= 1'b0;
            instruction_q <= 32'h0000_0000;
            addr_q        <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            instruction_q <= instruction_d;
            addr_q        <= addr_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
//============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder (DEPTH_WORDS = 4).
//               Expected words are pushed to a scoreboard when a request is
//               accepted and compared when the DUT writes them out.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_instr_encoder;

    localparam int          DEPTH     = 4;
    localparam logic [31:0] ADDR_SPAN = 32'(4 * DEPTH);

    logic        Clk = 1'b0;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [4:0]  OpSel, Rs, Rt, Rd, Shamt;
    logic [15:0] Imm;
    logic [25:0] Target;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Instruction;
    logic [31:0] InstrAddr;
    logic        WrEn;
    logic        Error;

    logic [31:0] sb_q[$];
    logic [31:0] exp_addr = 32'd0;
    bit          mon_en   = 1'b0;
    int          total    = 0;
    int          bad      = 0;

    instr_encoder #(.DEPTH_WORDS(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .OpSel(OpSel), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt),
        .Imm(Imm), .Target(Target), .OutValid(OutValid), .OutReady(OutReady),
        .Instruction(Instruction), .InstrAddr(InstrAddr), .WrEn(WrEn), .Error(Error)
    );

    always #5 Clk = ~Clk;

    // Reference encoder written from the instruction tables.
    function automatic logic [31:0] ref_encode(input logic [4:0] sel, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [4:0] rd,
                                               input logic [4:0] sh, input logic [15:0] imm,
                                               input logic [25:0] tgt);
        logic [5:0] op, fn;
        logic [4:0] ers, ert, erd, esh;
        int kind; // 0 register form, 1 immediate form, 2 jump form, 3 nop
        op = 6'h00; fn = 6'h00; kind = 3;
        ers = rs; ert = rt; erd = rd; esh = 5'd0;
        case (sel)
            5'd0:  begin kind = 0; fn = 6'h00; ers = 5'd0; esh = sh; end
            5'd1:  begin kind = 0; fn = 6'h02; ers = 5'd0; esh = sh; end
            5'd2:  begin kind = 0; fn = 6'h20; end
            5'd3:  begin kind = 0; fn = 6'h22; end
            5'd4:  begin kind = 0; fn = 6'h24; end
            5'd5:  begin kind = 0; fn = 6'h25; end
            5'd6:  begin kind = 0; fn = 6'h26; end
            5'd7:  begin kind = 0; fn = 6'h27; end
            5'd8:  begin kind = 0; fn = 6'h2A; end
            5'd9:  begin kind = 0; fn = 6'h08; ert = 5'd0; erd = 5'd0; end
            5'd10: begin kind = 0; op = 6'h1C; fn = 6'h02; end
            5'd11: begin kind = 1; op = 6'h23; end
            5'd12: begin kind = 1; op = 6'h20; end
            5'd13: begin kind = 1; op = 6'h21; end
            5'd14: begin kind = 1; op = 6'h2B; end
            5'd15: begin kind = 1; op = 6'h28; end
            5'd16: begin kind = 1; op = 6'h29; end
            5'd17: begin kind = 1; op = 6'h08; end
            5'd18: begin kind = 1; op = 6'h0C; end
            5'd19: begin kind = 1; op = 6'h0D; end
            5'd20: begin kind = 1; op = 6'h0E; end
            5'd21: begin kind = 1; op = 6'h0A; end
            5'd22: begin kind = 1; op = 6'h04; end
            5'd23: begin kind = 1; op = 6'h05; end
            5'd24: begin kind = 1; op = 6'h01; ert = 5'd1; end
            5'd25: begin kind = 1; op = 6'h01; ert = 5'd0; end
            5'd26: begin kind = 1; op = 6'h07; ert = 5'd0; end
            5'd27: begin kind = 1; op = 6'h06; ert = 5'd0; end
            5'd28: begin kind = 2; op = 6'h02; end
            5'd29: begin kind = 2; op = 6'h03; end
            default: kind = 3;
        endcase
        case (kind)
            0:       return {op, ers, ert, erd, esh, fn};
            1:       return {op, ers, ert, imm};
            2:       return {op, tgt};
            default: return 32'h0;
        endcase
    endfunction

    // Scoreboard monitor: every drained word must match the next expected word and address.
    always @(negedge Clk) begin
        if (mon_en && !Reset) begin
            total++;
            if (WrEn !== (OutValid && OutReady)) begin
                bad++;
                $display("FAIL wren_strobe got=%b want=%b", WrEn, OutValid && OutReady);
            end
            if (OutValid === 1'b1 && OutReady === 1'b1) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write instr=%h addr=%h want=none", Instruction, InstrAddr);
                end else begin
                    logic [31:0] exp_w;
                    exp_w = sb_q.pop_front();
                    if (Instruction !== exp_w || InstrAddr !== exp_addr) begin
                        bad++;
                        $display("FAIL write_word instr=%h addr=%h want instr=%h addr=%h",
                                 Instruction, InstrAddr, exp_w, exp_addr);
                    end
                    exp_addr = (exp_addr + 32'd4) % ADDR_SPAN;
                end
            end
        end
    end

    task automatic set_fields(input logic [4:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                              input logic [25:0] tgt);
        OpSel = sel; Rs = rs; Rt = rt; Rd = rd; Shamt = sh; Imm = imm; Target = tgt;
    endtask

    // Present a request until accepted; push the expected word when it is.
    task automatic send(input logic [4:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tgt, input bit expect_out);
        set_fields(sel, rs, rt, rd, sh, imm, tgt);
        InValid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (InReady === 1'b1) begin
                if (expect_out) sb_q.push_back(ref_encode(sel, rs, rt, rd, sh, imm, tgt));
                @(posedge Clk); #1;
                InValid = 1'b0;
                return;
            end
            @(posedge Clk); #1;
        end
        total++; bad++;
        $display("FAIL send_timeout sel=%0d got=not_accepted want=accepted", sel);
        InValid = 1'b0;
    endtask

    task automatic send_rand(input logic [4:0] sel, input bit expect_out);
        send(sel, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             16'($urandom), 26'($urandom), expect_out);
    endtask

    task automatic do_reset();
        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        sb_q.delete();
        exp_addr = 32'd0;
        mon_en = 1'b1;
    endtask

    task automatic drain();
        @(posedge Clk); #1;
        OutReady = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge Clk);
        total += 6;
        if (OutValid !== 1'b0) begin bad++; $display("FAIL rst_outvalid got=%b want=0", OutValid); end
        if (Instruction !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", Instruction); end
        if (InstrAddr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", InstrAddr); end
        if (Error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b want=0", Error); end
        if (WrEn !== 1'b0) begin bad++; $display("FAIL rst_wren got=%b want=0", WrEn); end
        if (InReady !== 1'b1) begin bad++; $display("FAIL rst_inready got=%b want=1", InReady); end
    endtask

    task automatic test_add_latency();
        do_reset();
        send(5'd2, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0, 26'h0, 1'b1);
        @(negedge Clk);
        total += 3;
        if (OutValid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", OutValid); end
        if (Instruction !== 32'h0022_1820) begin bad++; $display("FAIL add_word got=%h want=00221820", Instruction); end
        if (InstrAddr !== 32'h0) begin bad++; $display("FAIL add_addr got=%h want=0", InstrAddr); end
        drain();
    endtask

    task automatic test_back_to_back();
        do_reset();
        OutReady = 1'b1;
        sb_q.push_back(ref_encode(5'd11, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0));
        sb_q.push_back(ref_encode(5'd28, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h010_0000));
        set_fields(5'd11, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
        InValid = 1'b1;
        @(posedge Clk); #1;
        set_fields(5'd28, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h010_0000);
        @(negedge Clk);
        total += 2;
        if (Instruction !== 32'h8FA8_0004 || InstrAddr !== 32'h0)
            begin bad++; $display("FAIL b2b_lw instr=%h addr=%h want 8fa80004 @0", Instruction, InstrAddr); end
        if (WrEn !== 1'b1 || InReady !== 1'b1)
            begin bad++; $display("FAIL b2b_flow1 wren=%b inready=%b want 1 1", WrEn, InReady); end
        @(posedge Clk); #1;
        InValid = 1'b0;
        @(negedge Clk);
        total += 2;
        if (Instruction !== 32'h0810_0000 || InstrAddr !== 32'h4)
            begin bad++; $display("FAIL b2b_j instr=%h addr=%h want 08100000 @4", Instruction, InstrAddr); end
        if (WrEn !== 1'b1)
            begin bad++; $display("FAIL b2b_flow2 wren=%b want 1", WrEn); end
        drain();
    endtask

    task automatic test_forced_fields();
        @(posedge Clk); #1;
        OutReady = 1'b0;
        send(5'd0, 5'd7, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0, 1'b1);
        @(negedge Clk);
        total++;
        if (Instruction !== 32'h0003_1100) begin bad++; $display("FAIL sll_word got=%h want=00031100", Instruction); end
        @(posedge Clk); #1;
        OutReady = 1'b1;
        send(5'd24, 5'd4, 5'd9, 5'd5, 5'd3, 16'hFFFE, 26'h0, 1'b1);
        @(negedge Clk);
        total++;
        if (Instruction !== 32'h0481_FFFE) begin bad++; $display("FAIL bgez_word got=%h want=0481fffe", Instruction); end
        drain();
    endtask

    task automatic test_stall();
        logic [31:0] e_a, e_b, a_addr;
        @(posedge Clk); #1;
        OutReady = 1'b0;
        send(5'd17, 5'd6, 5'd7, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1);
        e_a    = ref_encode(5'd17, 5'd6, 5'd7, 5'd0, 5'd0, 16'h1234, 26'h0);
        a_addr = exp_addr;
        for (int i = 0; i < 3; i++) begin
            send_fields_noise: begin
                set_fields(5'($urandom_range(0, 29)), 5'($urandom), 5'($urandom), 5'($urandom),
                           5'($urandom), 16'($urandom), 26'($urandom));
            end
            InValid = 1'b1;
            @(negedge Clk);
            total++;
            if (InReady !== 1'b0 || Instruction !== e_a || InstrAddr !== a_addr || OutValid !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d inready=%b instr=%h addr=%h want 0 %h %h",
                         i, InReady, Instruction, InstrAddr, e_a, a_addr);
            end
            @(posedge Clk); #1;
        end
        set_fields(5'd6, 5'd10, 5'd11, 5'd12, 5'd13, 16'h0, 26'h0);
        e_b = ref_encode(5'd6, 5'd10, 5'd11, 5'd12, 5'd13, 16'h0, 26'h0);
        OutReady = 1'b1;
        @(negedge Clk);
        total++;
        if (WrEn !== 1'b1 || InReady !== 1'b1) begin
            bad++; $display("FAIL stall_release wren=%b inready=%b want 1 1", WrEn, InReady);
        end
        sb_q.push_back(e_b);
        @(posedge Clk); #1;
        InValid = 1'b0;
        @(negedge Clk);
        total++;
        if (Instruction !== e_b || OutValid !== 1'b1) begin
            bad++; $display("FAIL stall_next instr=%h valid=%b want %h 1", Instruction, OutValid, e_b);
        end
        drain();
    endtask

    task automatic test_all_ops();
        @(posedge Clk); #1;
        OutReady = 1'b1;
        for (int s = 0; s < 30; s++) send_rand(5'(s), 1'b1);
        drain();
    endtask

    task automatic test_wrap();
        do_reset();
        OutReady = 1'b1;
        for (int i = 0; i < 5; i++) send_rand(5'($urandom_range(0, 29)), 1'b1);
        drain();
        @(negedge Clk);
        total++;
        if (InstrAddr !== 32'h4) begin bad++; $display("FAIL wrap_addr got=%h want=4", InstrAddr); end
    endtask

    task automatic test_reset_mid();
        @(posedge Clk); #1;
        OutReady = 1'b0;
        send_rand(5'd3, 1'b1);
        Reset = 1'b1;
        @(negedge Clk);
        total++;
        if (WrEn !== 1'b0) begin bad++; $display("FAIL midrst_wren got=%b want=0", WrEn); end
        @(posedge Clk); #1;
        Reset = 1'b0;
        sb_q.delete();
        exp_addr = 32'd0;
        @(negedge Clk);
        total++;
        if (OutValid !== 1'b0 || InstrAddr !== 32'h0) begin
            bad++; $display("FAIL midrst_state valid=%b addr=%h want 0 0", OutValid, InstrAddr);
        end
        drain();
    endtask

    task automatic test_illegal();
        do_reset();
`ifdef ENC_ILLEGAL_CHECK_EN
        OutReady = 1'b1;
        send_rand(5'd31, 1'b0);
        @(negedge Clk);
        total++;
        if (OutValid !== 1'b0 || Error !== 1'b1) begin
            bad++; $display("FAIL illegal_drop valid=%b err=%b want 0 1", OutValid, Error);
        end
        send_rand(5'd4, 1'b1);
        drain();
        @(negedge Clk);
        total++;
        if (Error !== 1'b1) begin bad++; $display("FAIL illegal_sticky got=%b want=1", Error); end
        do_reset();
        @(negedge Clk);
        total++;
        if (Error !== 1'b0) begin bad++; $display("FAIL illegal_clear got=%b want=0", Error); end
`else
        send_rand(5'd31, 1'b1);
        @(negedge Clk);
        total++;
        if (OutValid !== 1'b1 || Instruction !== 32'h0 || Error !== 1'b0) begin
            bad++; $display("FAIL illegal_nop valid=%b instr=%h err=%b want 1 0 0", OutValid, Instruction, Error);
        end
        drain();
        send_rand(5'd30, 1'b1);
        drain();
`endif
    endtask

    task automatic test_drain_empty();
        drain();
        total++;
        if (sb_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
        set_fields(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        test_reset();
        test_add_latency();
        test_back_to_back();
        test_forced_fields();
        test_stall();
        test_all_ops();
        test_wrap();
        test_reset_mid();
        test_illegal();
        test_drain_empty();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH_WORDS, 64, instruction-memory depth in words; the address counter wraps at this value; power of two, at least 2.
REQ-002 Clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 InValid  in  1  request valid.
REQ-005 InReady  out  1  encoder can accept a request this cycle.
REQ-006 OpSel  in  5  mnemonic select (table in REQ-012).
REQ-007 Rs, Rt, Rd, Shamt  in  5 each  register and shift-amount fields.
REQ-008 Imm  in  16  immediate or branch offset, passed through unchanged.
REQ-009 Target  in  26  jump target field.
REQ-010 OutValid  out  1 / OutReady  in  1  output handshake.
REQ-011 Instruction  out  32 / InstrAddr  out  32 / WrEn  out  1 / Error  out  1  encoded word, its byte address, memory write strobe, illegal-op flag.

Function
REQ-012 OpSel codes, in order: 0 sll, 1 srl, 2 add, 3 sub, 4 and, 5 or, 6 xor, 7 nor, 8 slt, 9 jr, 10 mul, 11 lw, 12 lb, 13 lh, 14 sw, 15 sb, 16 sh, 17 addi, 18 andi, 19 ori, 20 xori, 21 slti, 22 beq, 23 bne, 24 bgez, 25 bltz, 26 bgtz, 27 blez, 28 j, 29 jal; codes 30 and 31 are illegal.
REQ-013 R-type words use op 000000 with fields rs|rt|rd|shamt|funct.
- Funct values: sll 000000, srl 000010, add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, slt 101010, jr 001000.
- sll and srl force rs to 0.
- Every other R-type op forces shamt to 0.
- jr also forces rt and rd to 0.
REQ-014 mul uses op 011100, rs|rt|rd, shamt 0, funct 000010.
REQ-015 I-type words are op|rs|rt|imm.
- Opcodes: lw 100011, lb 100000, lh 100001, sw 101011, sb 101000, sh 101001, addi 001000, andi 001100, ori 001101, xori 001110, slti 001010, beq 000100, bne 000101, bgtz 000111, blez 000110.
- bgtz and blez force rt to 0.
REQ-016 bgez and bltz use op 000001; the rt field is forced to 00001 for bgez and 00000 for bltz.
REQ-017 j uses op 000010 and jal uses op 000011, each followed by Target.
REQ-018 The block has a single output register.
- InReady = !OutValid || OutReady.
- A request is accepted when InValid && InReady.
- The encoded word appears on Instruction, with OutValid=1, exactly 1 cycle after acceptance.
REQ-019 While OutValid=1 and OutReady=0, Instruction and InstrAddr hold stable and no request is accepted.
REQ-020 WrEn = OutValid && OutReady (combinational).
- On each WrEn cycle, InstrAddr advances by 4.
- After the word at byte address 4*(DEPTH_WORDS-1), InstrAddr wraps to 0.
REQ-021 Simultaneous output drain and input accept in one cycle is supported.
- The new word is loaded in that cycle, with InstrAddr already advanced.
- Throughput is 1 word/cycle.
REQ-022 Output fields are taken from the accepted request only; input changes while not accepted have no effect.

Reset
REQ-023 When Reset=1 at a rising edge, on the next cycle: OutValid=0, Instruction=0, InstrAddr=0, Error=0, WrEn=0, InReady=1.
REQ-024 Reset asserted mid-transfer discards the held word; no WrEn is produced for it.

Configuration
REQ-025 Macro ENC_ILLEGAL_CHECK_EN.
- Defined: an accepted illegal OpSel is consumed but produces no output word, and Error is set and stays set (sticky) until Reset.
- Undefined: an illegal OpSel encodes as 32'h00000000 (nop) and proceeds normally; Error is tied to 0.

Verification
REQ-026 add, Rd=3, Rs=1, Rt=2 -> Instruction=0x00221820, InstrAddr=0 one cycle later.
REQ-027 lw, Rt=8, Rs=29, Imm=0x0004, then j with Target=0x0100000, OutReady=1 throughout -> 0x8FA80004 at address 0, then 0x08100000 at address 4, on consecutive cycles.
REQ-028 sll, Rd=2, Rt=3, Shamt=4, Rs=7 -> 0x00031100 (Rs ignored). bgez, Rs=4, Imm=0xFFFE -> 0x0481FFFE.
REQ-029 OutReady held at 0 for 3 cycles while InValid=1 -> InReady=0, and Instruction and InstrAddr stable. Release OutReady -> exactly one WrEn for that word, then the next request is accepted.
REQ-030 DEPTH_WORDS=4, 5 writes -> InstrAddr sequence 0, 4, 8, 12, 0. Reset asserted with OutValid=1 -> OutValid=0 and InstrAddr=0 the next cycle.
REQ-031 OpSel=31 -> with the macro: no OutValid and Error=1 until Reset. Without the macro: Instruction=0x00000000 with OutValid=1.
